imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 120 ++++++++++++
 tb/tb_imem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: turns PC fetch requests into ordered
// {pc, inst, err} responses through a sync SRAM and a 3-entry FIFO.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  fetch request handshake, req_addr = PC
//   flush                discard all buffered and inflight fetches
//   rsp_valid/rsp_ready  response handshake; rsp_pc/rsp_inst/rsp_err
//   mem_en/mem_addr      SRAM read port, mem_rdata one cycle later
module imem_responder #(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_pc,
  output logic [31:0]      rsp_inst,
  output logic             rsp_err,
  output logic             mem_en,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [31:0]      mem_rdata
);

  localparam int DEPTH = 3;

  logic [31:0] r_pc   [DEPTH];
  logic [31:0] r_inst [DEPTH];
  logic        r_err  [DEPTH];
  logic [1:0]  r_rd;
  logic [1:0]  r_wr;
  logic [1:0]  r_count;

  // Slot for the request accepted last cycle; faulting requests
  // ride along too so ordering and N+2 timing stay uniform.
  logic        r_inf_vld;
  logic [31:0] r_inf_pc;
  logic        r_inf_err;

  logic        w_fault;
  logic [2:0]  w_occ;
  logic        w_ready;
  logic        w_acc;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_inst;

  assign w_fault = (req_addr[1:0] != 2'b00) ||
                   (req_addr[31:IDX_W+2] != '0);

  // The inflight slot counts as occupied so a push can never
  // land on a full FIFO.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inf_vld};
  assign w_ready = rst_n && !flush && (w_occ < 3'd3);
  assign w_acc   = req_valid && w_ready;

  assign req_ready = w_ready;
  assign mem_en    = w_acc && !w_fault;
  assign mem_addr  = req_addr[IDX_W+1:2];

  assign w_push      = r_inf_vld && !flush;
  assign w_pop       = (r_count != 2'd0) && rsp_ready && !flush;
  assign w_push_inst = r_inf_err ? 32'h0 : mem_rdata;

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_pc    = rsp_valid ? r_pc[r_rd]   : 32'h0;
  assign rsp_inst  = rsp_valid ? r_inst[r_rd] : 32'h0;
  assign rsp_err   = rsp_valid ? r_err[r_rd]  : 1'b0;

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inf_vld <= 1'b0;
      r_inf_pc  <= 32'h0;
      r_inf_err <= 1'b0;
    end else begin
      r_inf_vld <= w_acc;
      if (w_acc) begin
        r_inf_pc  <= req_addr;
        r_inf_err <= w_fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= 2'd0;
      r_wr    <= 2'd0;
      r_count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= 32'h0;
        r_inst[i] <= 32'h0;
        r_err[i]  <= 1'b0;
      end
    end else if (flush) begin
      r_rd    <= 2'd0;
      r_wr    <= 2'd0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc[r_wr]   <= r_inf_pc;
        r_inst[r_wr] <= w_push_inst;
        r_err[r_wr]  <= r_inf_err;
        r_wr         <= inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= inc(r_rd);
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios then
// random traffic against a queue-based reference of fetch responses.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;

  imem_responder #(.IDX_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pc    (rsp_pc),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [4096];

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    int          t;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance model.
  // Every accepted fetch yields one response visible two cycles on.
  task automatic step(input logic v, input logic [31:0] a,
                      input logic rr, input logic fl);
    logic exp_rdy;
    logic exp_rv;
    logic flt;
    ent_t e;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    #1;
    exp_rdy = !fl && (q.size() < 3);
    exp_rv  = (q.size() > 0) && (q[0].t + 2 <= cyc);
    flt     = (a[1:0] != 2'b00) || (a[31:14] != 18'h0);
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_rdy});
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv});
    if (exp_rv) begin
      chk("rsp_pc", rsp_pc, q[0].pc);
      chk("rsp_inst", rsp_inst, q[0].inst);
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, q[0].err});
    end
    chk("mem_en", {31'h0, mem_en},
        {31'h0, v && exp_rdy && !flt});
    if (v) chk("mem_addr", {20'h0, mem_addr}, {20'h0, a[13:2]});
    if (fl) begin
      q.delete();
    end else begin
      if (exp_rv && rr) void'(q.pop_front());
      if (v && exp_rdy) begin
        e.pc   = a;
        e.inst = flt ? 32'h0 : mem[a[13:2]];
        e.err  = flt;
        e.t    = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_pc", rsp_pc, 32'h0);
    chk("rst_rsp_inst", rsp_inst, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic        v;
    logic        rr;
    logic        fl;
    int          r;
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[2] = 32'h0010_0093;

    #3;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // single fetch at 0x8
    step(1'b1, 32'h8, 1'b1, 1'b0);
    idle(4);

    // back-to-back fetches, no bubbles
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i * 4), 1'b1, 1'b0);
    idle(4);

    // backpressure: 3 accepted, then stall, then drain
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    idle(5);

    // faulting fetches
    step(1'b1, 32'h0000_0002, 1'b1, 1'b0);
    step(1'b1, 32'h0001_0000, 1'b1, 1'b0);
    idle(4);

    // flush with 2 buffered + 1 inflight, then refetch
    step(1'b1, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h208, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b0);
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        step(1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk_reset_outs();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {31'h0, req_ready}, 32'h1);
        cyc += 2;
      end
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 31) == 0);
      r  = $urandom_range(0, 15);
      if (r == 0)
        a = {18'h0, 12'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 1)
        a = {18'($urandom_range(1, 262143)), 14'($urandom)};
      else
        a = {18'h0, 12'($urandom), 2'b00};
      step(v, a, rr, fl);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
